// File: rtl/masked_barith_pipe_if.sv
// Operand, randomness and result bundle for the two-share masked adder.
// The master drives operands and randomness; the slave is the datapath.
interface masked_barith_pipe_if #(
  parameter int XLEN = 32
);
  logic              flush;
  logic              i_valid;
  logic              i_ready;
  logic              i_sub;
  logic [XLEN-1:0]   i_a0;
  logic [XLEN-1:0]   i_a1;
  logic [XLEN-1:0]   i_b0;
  logic [XLEN-1:0]   i_b1;
  logic [2*XLEN-1:0] i_rnd;
  logic              rnd_req;
  logic              o_valid;
  logic [XLEN-1:0]   o_s0;
  logic [XLEN-1:0]   o_s1;

  modport master (
    output flush, i_valid, i_sub, i_a0, i_a1, i_b0, i_b1, i_rnd,
    input  i_ready, rnd_req, o_valid, o_s0, o_s1
  );

  modport slave (
    input  flush, i_valid, i_sub, i_a0, i_a1, i_b0, i_b1, i_rnd,
    output i_ready, rnd_req, o_valid, o_s0, o_s1
  );
endinterface

// File: rtl/masked_barith_pipe.sv
// Two-share Boolean-masked add/sub: DOM generate/propagate, then a Kogge-Stone prefix, two cycles per level.
// Level randomness is captured one cycle ahead, so rnd_req fires in GEN0, GEN1 and every non-final ph1.
module masked_barith_pipe #(
  parameter int XLEN = 32
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  masked_barith_pipe_if.slave  bus
);
  localparam int LEVELS = $clog2(XLEN);
  localparam int LVL_W  = $clog2(LEVELS + 1);

  typedef logic [XLEN-1:0] word_t;
  typedef enum logic [2:0] {S_IDLE, S_GEN0, S_GEN1, S_PH0, S_PH1, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              last_lvl;

  word_t             a0_q, a1_q, b0_q, b1_q;
  logic              sub_q;
  word_t             pi0_q, pi1_q;
  word_t             t00_q, t01_q, t10_q, t11_q;
  word_t             u00_q, u01_q, u10_q, u11_q;
  word_t             g0_q, g1_q, p0_q, p1_q;
  logic [2*XLEN-1:0] rnd_q;

  word_t             gs0, gs1, ps0, ps1, rg, rp;

  assign last_lvl = (lvl_q == LVL_W'(LEVELS - 1));
  assign gs0 = g0_q << (32'd1 << lvl_q);
  assign gs1 = g1_q << (32'd1 << lvl_q);
  assign ps0 = p0_q << (32'd1 << lvl_q);
  assign ps1 = p1_q << (32'd1 << lvl_q);
  assign rg  = rnd_q[XLEN-1:0];
  assign rp  = rnd_q[2*XLEN-1:XLEN];

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    bus.i_ready = 1'b0;
    bus.rnd_req = 1'b0;
    bus.o_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        bus.i_ready = 1'b1;
        lvl_d       = '0;
        if (bus.i_valid) state_d = S_GEN0;
      end
      S_GEN0: begin
        bus.rnd_req = 1'b1;
        state_d     = S_GEN1;
      end
      S_GEN1: begin
        bus.rnd_req = 1'b1;
        state_d     = S_PH0;
      end
      S_PH0: state_d = S_PH1;
      S_PH1: begin
        if (last_lvl) begin
          state_d = S_DONE;
        end else begin
          bus.rnd_req = 1'b1;
          lvl_d       = lvl_q + LVL_W'(1);
          state_d     = S_PH0;
        end
      end
      S_DONE: begin
        bus.o_valid = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_s0 = (state_q == S_DONE) ? (pi0_q ^ {g0_q[XLEN-2:0], 1'b0})  : '0;
  assign bus.o_s1 = (state_q == S_DONE) ? (pi1_q ^ {g1_q[XLEN-2:0], sub_q}) : '0;

  // NOTE: sequential state uses non-blocking assignments only; flush and reset share one synchronous clear of every register.
  always_ff @(posedge g_clk) begin
    if (!g_resetn || bus.flush) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      a0_q    <= '0;  a1_q  <= '0;  b0_q  <= '0;  b1_q  <= '0;  sub_q <= 1'b0;
      pi0_q   <= '0;  pi1_q <= '0;
      t00_q   <= '0;  t01_q <= '0;  t10_q <= '0;  t11_q <= '0;
      u00_q   <= '0;  u01_q <= '0;  u10_q <= '0;  u11_q <= '0;
      g0_q    <= '0;  g1_q  <= '0;  p0_q  <= '0;  p1_q  <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      // Product registers hold share cross-terms for exactly one cycle, then return to zero.
      t00_q <= '0;  t01_q <= '0;  t10_q <= '0;  t11_q <= '0;
      u00_q <= '0;  u01_q <= '0;  u10_q <= '0;  u11_q <= '0;
      case (state_q)
        S_IDLE: begin
          a0_q  <= bus.i_valid ? bus.i_a0 : '0;
          a1_q  <= bus.i_valid ? bus.i_a1 : '0;
          b0_q  <= bus.i_valid ? (bus.i_sub ? ~bus.i_b0 : bus.i_b0) : '0;
          b1_q  <= bus.i_valid ? bus.i_b1 : '0;
          sub_q <= bus.i_valid & bus.i_sub;
          pi0_q <= '0;  pi1_q <= '0;
          g0_q  <= '0;  g1_q  <= '0;  p0_q <= '0;  p1_q <= '0;
          rnd_q <= '0;
        end
        S_GEN0: begin
          pi0_q <= a0_q ^ b0_q;
          pi1_q <= a1_q ^ b1_q;
          t00_q <= a0_q & b0_q;
          t01_q <= (a0_q & b1_q) ^ bus.i_rnd[XLEN-1:0];
          t10_q <= (a1_q & b0_q) ^ bus.i_rnd[XLEN-1:0];
          t11_q <= a1_q & b1_q;
        end
        S_GEN1: begin
          // Carry-in of one for subtraction, folded into bit 0 of each generate share.
          g0_q  <= t00_q ^ t01_q ^ {{(XLEN-1){1'b0}}, sub_q & pi0_q[0]};
          g1_q  <= t10_q ^ t11_q ^ {{(XLEN-1){1'b0}}, sub_q & pi1_q[0]};
          p0_q  <= pi0_q;
          p1_q  <= pi1_q;
          rnd_q <= bus.i_rnd;
        end
        S_PH0: begin
          t00_q <= p0_q & gs0;
          t01_q <= (p0_q & gs1) ^ rg ^ g0_q;
          t10_q <= (p1_q & gs0) ^ rg ^ g1_q;
          t11_q <= p1_q & gs1;
          u00_q <= p0_q & ps0;
          u01_q <= (p0_q & ps1) ^ rp;
          u10_q <= (p1_q & ps0) ^ rp;
          u11_q <= p1_q & ps1;
        end
        S_PH1: begin
          g0_q <= t00_q ^ t01_q;
          g1_q <= t10_q ^ t11_q;
          p0_q <= u00_q ^ u01_q;
          p1_q <= u10_q ^ u11_q;
          if (!last_lvl) rnd_q <= bus.i_rnd;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_masked_barith_pipe.sv
// Bench for masked_barith_pipe at XLEN 8/16/32/64: vector table, flush/reset sequences and random ops
// against a plain-arithmetic reference.
module tb_masked_barith_pipe;
  logic g_clk = 1'b0;
  logic g_resetn;
  always #5 g_clk = ~g_clk;

  logic [3:0]         flush, vld, sub_v, rdy, rreq, ov;
  logic [3:0][63:0]   a0, a1, b0, b1, s0, s1;
  logic [3:0][127:0]  rnd;

  int total = 0;
  int bad   = 0;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam int W = 8 << i;
    masked_barith_pipe_if #(.XLEN(W)) bus ();
    masked_barith_pipe #(.XLEN(W)) u_dut (
      .g_clk    (g_clk),
      .g_resetn (g_resetn),
      .bus      (bus.slave)
    );
    assign bus.flush   = flush[i];
    assign bus.i_valid = vld[i];
    assign bus.i_sub   = sub_v[i];
    assign bus.i_a0    = a0[i][W-1:0];
    assign bus.i_a1    = a1[i][W-1:0];
    assign bus.i_b0    = b0[i][W-1:0];
    assign bus.i_b1    = b1[i][W-1:0];
    assign bus.i_rnd   = rnd[i][2*W-1:0];
    assign rdy[i]      = bus.i_ready;
    assign rreq[i]     = bus.rnd_req;
    assign ov[i]       = bus.o_valid;
    assign s0[i]       = 64'(bus.o_s0);
    assign s1[i]       = 64'(bus.o_s1);
  end

  typedef struct {
    int          lat;
    int          nvalid;
    int          rdy_cyc;
    logic [63:0] rreq;
    bit          quiet;
    logic [63:0] res;
    logic [63:0] sh0;
  } obs_t;

  typedef struct {
    int          lane;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] exp;
  } vec_t;

  function automatic logic [63:0] lmask(input int l);
    return (l == 3) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 << l)) - 64'd1);
  endfunction

  function automatic int levels(input int l);
    return 3 + l;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] model(input int l, input logic [63:0] a, input logic [63:0] b,
                                        input logic sub);
    return sub ? ((a - b) & lmask(l)) : ((a + b) & lmask(l));
  endfunction

  function automatic logic [63:0] exp_rreq(input int l);
    logic [63:0] m;
    m    = '0;
    m[1] = 1'b1;
    for (int k = 0; k < levels(l); k++) m[2 + 2*k] = 1'b1;
    return m;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // Issue one operation with a fresh random share split and observe it until i_ready returns.
  task automatic run_op(input int l, input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input int flush_at, output obs_t o);
    logic [63:0] m, ra, rb;
    m         = lmask(l);
    o.lat     = -1;
    o.nvalid  = 0;
    o.rdy_cyc = -1;
    o.rreq    = '0;
    o.quiet   = 1'b1;
    o.res     = '0;
    o.sh0     = '0;
    ra = rand64() & m;
    rb = rand64() & m;
    @(negedge g_clk);
    vld[l]   = 1'b1;
    sub_v[l] = sub;
    a0[l]    = ra;
    a1[l]    = (a ^ ra) & m;
    b0[l]    = rb;
    b1[l]    = (b ^ rb) & m;
    rnd[l]   = {rand64(), rand64()};
    @(posedge g_clk);
    for (int c = 1; c <= 2*levels(l) + 8 && o.rdy_cyc < 0; c++) begin
      @(negedge g_clk);
      vld[l]   = 1'b0;
      flush[l] = 1'b0;
      if (ov[l]) begin
        o.nvalid++;
        if (o.lat < 0) begin
          o.lat = c;
          o.res = s0[l] ^ s1[l];
          o.sh0 = s0[l];
        end
      end else if (s0[l] != '0 || s1[l] != '0) begin
        o.quiet = 1'b0;
      end
      if (rreq[l]) o.rreq[c] = 1'b1;
      if (rdy[l] && o.rdy_cyc < 0) o.rdy_cyc = c;
      rnd[l] = {rand64(), rand64()};
      if (c == flush_at) flush[l] = 1'b1;
    end
  endtask

  task automatic check_op(input string name, input int l, input obs_t o, input logic [63:0] exp);
    check({name, "_result"}, o.res, exp);
    check({name, "_latency"}, 64'(o.lat), 64'(3 + 2*levels(l)));
    check({name, "_nvalid"}, 64'(o.nvalid), 64'd1);
    check({name, "_ready_back"}, 64'(o.rdy_cyc), 64'(4 + 2*levels(l)));
    check({name, "_rnd_req"}, o.rreq, exp_rreq(l));
    check({name, "_idle_zero"}, 64'(o.quiet), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[10];
    obs_t        o;
    logic [63:0] sh[3];
    logic [63:0] a, b, m;
    logic        sub;

    vecs[0] = '{2, 64'h7FFF_FFFF,           64'h1,                  1'b0, 64'h8000_0000};
    vecs[1] = '{2, 64'h5,                   64'h7,                  1'b1, 64'hFFFF_FFFE};
    vecs[2] = '{2, 64'hDEAD_BEEF,           64'hDEAD_BEEF,          1'b1, 64'h0};
    vecs[3] = '{0, 64'hFF,                  64'h01,                 1'b0, 64'h00};
    vecs[4] = '{0, 64'h00,                  64'h01,                 1'b1, 64'hFF};
    vecs[5] = '{1, 64'h8000,                64'h8000,               1'b0, 64'h0000};
    vecs[6] = '{1, 64'h1234,                64'h4321,               1'b1, 64'hCF13};
    vecs[7] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1,                  1'b0, 64'h0};
    vecs[8] = '{3, 64'h0,                   64'h1,                  1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[9] = '{2, 64'h1234_5678,           64'h9ABC_DEF0,          1'b0, 64'hACF1_3568};

    g_resetn = 1'b0;
    flush = '0;  vld = '0;  sub_v = '0;
    a0 = '0;  a1 = '0;  b0 = '0;  b1 = '0;  rnd = '0;
    repeat (3) @(negedge g_clk);
    check("reset_ready", 64'(rdy), 64'hF);
    check("reset_o_valid", 64'(ov), 64'h0);
    check("reset_rnd_req", 64'(rreq), 64'h0);
    for (int l = 0; l < 4; l++) check($sformatf("reset_shares_l%0d", l), s0[l] | s1[l], 64'h0);
    g_resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].lane, vecs[i].a, vecs[i].b, vecs[i].sub, -1, o);
      check_op($sformatf("vec%0d", i), vecs[i].lane, o, vecs[i].exp);
    end

    // Flush at T+5 of a 32-bit add, then a clean operation.
    run_op(2, 64'h0123_4567, 64'h89AB_CDEF, 1'b0, 5, o);
    check("flush_no_valid", 64'(o.nvalid), 64'd0);
    check("flush_ready_t6", 64'(o.rdy_cyc), 64'd6);
    check("flush_zero_out", 64'(o.quiet), 64'd1);
    run_op(2, 64'h0123_4567, 64'h89AB_CDEF, 1'b0, -1, o);
    check_op("after_flush", 2, o, 64'h8ACF_1356);

    // Flush coinciding with a valid operand in IDLE must win.
    @(negedge g_clk);
    vld[0] = 1'b1;  flush[0] = 1'b1;  a1[0] = 64'h11;  b1[0] = 64'h22;
    @(negedge g_clk);
    vld[0] = 1'b0;  flush[0] = 1'b0;
    check("flush_vs_accept_ready", 64'(rdy[0]), 64'd1);
    check("flush_vs_accept_no_req", 64'(rreq[0]), 64'd0);

    // Same operands, three share splits and randomness streams.
    for (int r = 0; r < 3; r++) begin
      run_op(2, 64'h1234_5678, 64'h9ABC_DEF0, 1'b0, -1, o);
      check($sformatf("split%0d_result", r), o.res, 64'hACF1_3568);
      sh[r] = o.sh0;
    end
    check("split_shares_differ", 64'(sh[0] != sh[1] && sh[1] != sh[2] && sh[0] != sh[2]), 64'd1);

    // Reset in the middle of a 64-bit operation.
    @(negedge g_clk);
    vld[3] = 1'b1;  sub_v[3] = 1'b1;  a0[3] = rand64();  a1[3] = rand64();
    b0[3]  = rand64();  b1[3] = rand64();
    @(negedge g_clk);
    vld[3] = 1'b0;
    repeat (4) @(negedge g_clk);
    g_resetn = 1'b0;
    @(negedge g_clk);
    check("midreset_ready", 64'(rdy), 64'hF);
    check("midreset_o_valid", 64'(ov), 64'h0);
    check("midreset_rnd_req", 64'(rreq), 64'h0);
    for (int l = 0; l < 4; l++) check($sformatf("midreset_shares_l%0d", l), s0[l] | s1[l], 64'h0);
    g_resetn = 1'b1;
    run_op(3, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, -1, o);
    check_op("after_reset", 3, o, 64'h0DEB_C9A7_8563_411F);

    // Constrained-random add/sub on every width.
    for (int n = 0; n < 40; n++) begin
      for (int l = 0; l < 4; l++) begin
        m   = lmask(l);
        a   = rand64() & m;
        b   = rand64() & m;
        sub = 1'($urandom_range(0, 1));
        run_op(l, a, b, sub, -1, o);
        check_op($sformatf("rand%0d_l%0d", n, l), l, o, model(l, a, b, sub));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
